// File: rtl/sequenciador_tabela_pkg.sv
// Shared types and constants for the truth-table sequencer (package pkg_tabela).
package pkg_tabela;

    localparam int unsigned N_VETORES         = 8;
    localparam int unsigned W_INDICE          = 3;
    localparam int unsigned W_CONTAGEM        = 4;
    localparam int unsigned W_ESPERA          = 4;
    localparam int unsigned CONTAGEM_ESPERADA = 1;
    localparam logic [N_VETORES-1:0] ESPERADO = 8'h80;

    typedef enum logic [1:0] {
        OCIOSO,
        APLICA,
        AMOSTRA,
        FIM
    } estado_t;

    // Captured sweep result: truth table plus its population count
    typedef struct packed {
        logic [N_VETORES-1:0]  tabela;
        logic [W_CONTAGEM-1:0] contagem;
    } resultado_t;

endpackage

// File: rtl/sequenciador_tabela_avaliador.sv
// Circuit under evaluation: three-input AND of the applied vector.
module avaliador_and3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic x
);

    assign x = a & b & c;

endmodule

// File: rtl/sequenciador_tabela.sv
// Sweeps all 8 input vectors through avaliador_and3 and captures its truth table.
// Optional self-check against the expected table: define VERIFICA_ESPERADO_EN.
module sequenciador_tabela
    import pkg_tabela::*;
#(
    parameter int unsigned ESPERA = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  aborta,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic [W_INDICE-1:0]   indice,
    output logic [N_VETORES-1:0]  tabela,
    output logic [W_CONTAGEM-1:0] contagem,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  erro
);

    localparam logic [W_ESPERA-1:0] ESPERA_FIM = W_ESPERA'(ESPERA - 1);
    localparam logic [W_INDICE-1:0] ULTIMO     = W_INDICE'(N_VETORES - 1);

    estado_t               estado, estado_nxt;
    logic [W_INDICE-1:0]   indice_nxt;
    logic [W_ESPERA-1:0]   espera_cnt, espera_nxt;
    resultado_t            res_q, res_nxt;
    logic                  ocupado_nxt;
    logic                  pronto_nxt;
    logic                  x;

    avaliador_and3 u_avaliador (
        .a (a),
        .b (b),
        .c (c),
        .x (x)
    );

    assign a        = indice[2];
    assign b        = indice[1];
    assign c        = indice[0];
    assign tabela   = res_q.tabela;
    assign contagem = res_q.contagem;

    // Next-state and datapath decode
    always_comb begin
        estado_nxt = estado;
        indice_nxt = indice;
        espera_nxt = espera_cnt;
        res_nxt    = res_q;
        pronto_nxt = 1'b0;

        case (estado)
            OCIOSO: begin
                if (start && !aborta) begin
                    estado_nxt = APLICA;
                    indice_nxt = '0;
                    espera_nxt = '0;
                    res_nxt    = '0;
                end
            end
            APLICA: begin
                if (aborta) begin
                    estado_nxt = OCIOSO;
                    indice_nxt = '0;
                    espera_nxt = '0;
                    res_nxt    = '0;
                end else if (espera_cnt == ESPERA_FIM) begin
                    estado_nxt = AMOSTRA;
                    espera_nxt = '0;
                end else begin
                    espera_nxt = espera_cnt + W_ESPERA'(1);
                end
            end
            AMOSTRA: begin
                if (aborta) begin
                    estado_nxt = OCIOSO;
                    indice_nxt = '0;
                    espera_nxt = '0;
                    res_nxt    = '0;
                end else begin
                    res_nxt.tabela[indice] = x;
                    res_nxt.contagem       = res_q.contagem + W_CONTAGEM'(x);
                    if (indice == ULTIMO) begin
                        estado_nxt = FIM;
                        pronto_nxt = 1'b1;
                    end else begin
                        estado_nxt = APLICA;
                        indice_nxt = indice + W_INDICE'(1);
                    end
                end
            end
            FIM: begin
                estado_nxt = OCIOSO;
            end
            default: begin
                estado_nxt = OCIOSO;
            end
        endcase

        ocupado_nxt = (estado_nxt == APLICA) || (estado_nxt == AMOSTRA);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado     <= OCIOSO;
            indice     <= '0;
            espera_cnt <= '0;
            res_q      <= '0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
        end else begin
            estado     <= estado_nxt;
            indice     <= indice_nxt;
            espera_cnt <= espera_nxt;
            res_q      <= res_nxt;
            ocupado    <= ocupado_nxt;
            pronto     <= pronto_nxt;
        end
    end

`ifdef VERIFICA_ESPERADO_EN
    logic erro_nxt;
    logic aceita;
    logic cancela;

    assign aceita  = (estado == OCIOSO) && (estado_nxt == APLICA);
    assign cancela = ((estado == APLICA) || (estado == AMOSTRA)) && (estado_nxt == OCIOSO);

    // Judged on the final table so erro rises in the same cycle as pronto
    always_comb begin
        erro_nxt = erro;
        if (pronto_nxt) begin
            erro_nxt = (res_nxt.tabela != ESPERADO) ||
                       (res_nxt.contagem != W_CONTAGEM'(CONTAGEM_ESPERADA));
        end else if (aceita || cancela) begin
            erro_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            erro <= 1'b0;
        end else begin
            erro <= erro_nxt;
        end
    end
`else
    assign erro = 1'b0;
`endif

endmodule

// File: doc/sequenciador_tabela.md
SEQUENCIADOR_TABELA -- requirements
Module: sequenciador_tabela

Interface
REQ-001 Parameter ESPERA, default 1, number of clock cycles each input vector is held before it is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  level; request a full truth-table sweep; sampled only in OCIOSO.
REQ-005 aborta  input  1  level; cancels a sweep in progress.
REQ-006 a, b, c  output  1 each  current vector applied to the evaluated circuit; a = indice[2], b = indice[1], c = indice[0].
REQ-007 indice  output  3  index of the vector currently applied.
REQ-008 tabela  output  8  captured truth table; bit i = circuit output for vector i.
REQ-009 contagem  output  4  number of vectors with output 1 (0..8).
REQ-010 ocupado  output  1  high in APLICA and AMOSTRA.
REQ-011 pronto  output  1  one-cycle pulse when a sweep completes.
REQ-012 erro  output  1  self-check flag (see Configuration).

Function
REQ-013 The evaluated circuit SHALL compute x = a & b & c, purely combinationally, from the registered a, b, c.
REQ-014 States: OCIOSO, APLICA, AMOSTRA, FIM; all outputs are registered or decoded from state.
REQ-015 OCIOSO: start=1 and aborta=0 -> APLICA; indice, tabela, contagem, erro cleared on the same edge.
REQ-016 APLICA: hold the vector ESPERA cycles (internal counter 0..ESPERA-1), then -> AMOSTRA.
REQ-017 AMOSTRA (one cycle): tabela[indice] <= x; contagem += x; indice==7 -> FIM, else indice += 1 and -> APLICA.
REQ-018 FIM (one cycle): pronto=1; -> OCIOSO; indice SHALL NOT wrap past 7 within a sweep.
REQ-019 Latency: start accepted in cycle t -> pronto high in cycle t+1+8*(ESPERA+1).
REQ-020 start while ocupado or in FIM SHALL be ignored; no queueing.
REQ-021 aborta=1 in APLICA or AMOSTRA -> OCIOSO next edge; tabela, contagem, indice cleared; pronto not asserted.
REQ-022 start and aborta both high in OCIOSO: aborta wins, stay in OCIOSO.
REQ-023 tabela, contagem, erro SHALL hold after pronto until the next accepted start, abort or reset.

Reset
REQ-024 rst_n=0 at a rising edge -> OCIOSO; a, b, c, indice, tabela, contagem, ocupado, pronto, erro all 0; applies mid-sweep identically, with no pronto.

Configuration
REQ-025 Macro VERIFICA_ESPERADO_EN defined: in FIM erro <= (tabela_final != ESPERADO) | (contagem_final != 1), registered together with pronto.
REQ-026 Macro undefined: erro port present and tied to 0; no comparator logic.

Structure
REQ-027 Shared package pkg_tabela: state enum (OCIOSO, APLICA, AMOSTRA, FIM), N_VETORES = 8, ESPERADO = 8'h80.
REQ-028 One sub-module, avaliador_and3 (inputs a, b, c; output x); the evaluated function lives only there.

Verification
REQ-029 Reset, then start=1 for one cycle, ESPERA=1 -> pronto in cycle t+17; tabela=8'h80, contagem=1, erro=0.
REQ-030 ESPERA=3 -> pronto in cycle t+33; each vector stable exactly 3 cycles before its sample; indice steps 0..7 exactly once.
REQ-031 aborta=1 during indice=4 -> OCIOSO next edge, tabela=0, contagem=0, no pronto; a new start gives full result 8'h80.
REQ-032 start held high throughout the sweep -> ignored while ocupado; new sweep begins the cycle after FIM, tables cleared at acceptance.
REQ-033 rst_n=0 for one cycle at indice=6 -> all outputs 0 next cycle, no pronto; start=1 together with aborta=1 in OCIOSO -> no sweep.
REQ-034 With VERIFICA_ESPERADO_EN and avaliador_and3 forced to x = a & b -> tabela=8'hC0, contagem=2, erro=1 with pronto.
